// File: rtl/miriscv_instr_fetch.sv
// miriscv_instr_fetch
//   Instruction fetch stage. Issues sequential word requests to instruction
//   memory (req/gnt/rvalid, at most 2 outstanding), buffers responses in a
//   2-entry FIFO feeding decode, and handles redirects (force) and kills.
//   In-flight responses that belong to a flushed stream are dropped.
//
// Ports
//   clk_i, arstn_i               clock, asynchronous active-low reset
//   cu_stall_f_i                 decode not accepting; FIFO head held
//   cu_kill_f_i                  flush, restart at oldest unconsumed PC
//   cu_force_pc_i/_target_i      flush, restart at target (wins over kill)
//   instr_req_o/addr_o/gnt_i     memory request channel
//   instr_rvalid_i/rdata_i       memory response channel (in order)
//   f_valid_o/instr_o            FIFO head to decode
//   f_current_pc_o/next_pc_o     head PC and head PC + 4
module miriscv_instr_fetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            cu_stall_f_i,
    input  logic            cu_kill_f_i,
    input  logic            cu_force_pc_i,
    input  logic [XLEN-1:0] cu_force_pc_target_i,
    output logic            instr_req_o,
    output logic [XLEN-1:0] instr_addr_o,
    input  logic            instr_gnt_i,
    input  logic            instr_rvalid_i,
    input  logic [ILEN-1:0] instr_rdata_i,
    output logic            f_valid_o,
    output logic [ILEN-1:0] f_instr_o,
    output logic [XLEN-1:0] f_current_pc_o,
    output logic [XLEN-1:0] f_next_pc_o
);

    logic [XLEN-1:0] fetch_pc;
    logic [1:0]      out_cnt;
    logic [1:0]      discard_cnt;
    logic [1:0]      fifo_cnt;

    // PCs of granted-but-unanswered requests, oldest in slot 0
    logic [XLEN-1:0] inf_pc     [2];
    // FIFO, head in slot 0; next PC stored so outputs come straight from flops
    logic [ILEN-1:0] fifo_instr [2];
    logic [XLEN-1:0] fifo_pc    [2];
    logic [XLEN-1:0] fifo_npc   [2];

    logic            flush;
    logic            pop_req;
    logic            pop;
    logic            gnt_acc;
    logic            rv;
    logic            drop;
    logic            push;
    logic [1:0]      live;
    logic [1:0]      cnt_after_pop;
    logic [1:0]      inf_slot;
    logic [2:0]      occ;
    logic [XLEN-1:0] kill_pc;

    assign flush         = cu_force_pc_i | cu_kill_f_i;
    assign pop_req       = f_valid_o & ~cu_stall_f_i;
    // the head is never consumed in a flush cycle
    assign pop           = pop_req & ~flush;
    assign live          = out_cnt - discard_cnt;
    assign occ           = {1'b0, live} + {1'b0, fifo_cnt} - {2'b00, pop_req};
    assign instr_req_o   = arstn_i & ~flush & (out_cnt < 2'd2) & (occ < 3'd2);
    assign instr_addr_o  = fetch_pc;
    assign gnt_acc       = instr_req_o & instr_gnt_i;
    // a response with nothing outstanding is ignored
    assign rv            = instr_rvalid_i & (out_cnt != 2'd0);
    assign drop          = rv & (discard_cnt != 2'd0);
    assign push          = rv & ~drop & ~flush;
    assign cnt_after_pop = fifo_cnt - {1'b0, pop};
    assign inf_slot      = out_cnt - {1'b0, rv};

    assign f_valid_o      = (fifo_cnt != 2'd0);
    assign f_instr_o      = fifo_instr[0];
    assign f_current_pc_o = fifo_pc[0];
    assign f_next_pc_o    = fifo_npc[0];

    // Oldest unconsumed PC: FIFO head, else first live in-flight, else fetch_pc.
    // Live entries sit behind the discarded ones in the in-flight queue.
    always_comb begin
        kill_pc = fetch_pc;
        if (fifo_cnt != 2'd0) begin
            kill_pc = fifo_pc[0];
        end else if (live != 2'd0) begin
            kill_pc = discard_cnt[0] ? inf_pc[1] : inf_pc[0];
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            fetch_pc    <= RESET_PC;
            out_cnt     <= '0;
            discard_cnt <= '0;
            fifo_cnt    <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                inf_pc[i]     <= '0;
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
                fifo_npc[i]   <= '0;
            end
        end else begin
            out_cnt <= out_cnt + {1'b0, gnt_acc} - {1'b0, rv};

            if (rv) begin
                inf_pc[0] <= inf_pc[1];
            end
            if (gnt_acc) begin
                inf_pc[inf_slot[0]] <= fetch_pc;
            end

            if (flush) begin
                fifo_cnt    <= '0;
                discard_cnt <= out_cnt - {1'b0, rv} + {1'b0, gnt_acc};
                fetch_pc    <= cu_force_pc_i ? cu_force_pc_target_i : kill_pc;
            end else begin
                if (drop) begin
                    discard_cnt <= discard_cnt - 2'd1;
                end
                if (gnt_acc) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (pop) begin
                    fifo_instr[0] <= fifo_instr[1];
                    fifo_pc[0]    <= fifo_pc[1];
                    fifo_npc[0]   <= fifo_npc[1];
                end
                // push lands after the shift, so it overrides slot 0 when needed
                if (push) begin
                    fifo_instr[cnt_after_pop[0]] <= instr_rdata_i;
                    fifo_pc[cnt_after_pop[0]]    <= inf_pc[0];
                    fifo_npc[cnt_after_pop[0]]   <= inf_pc[0] + XLEN'(4);
                end
                fifo_cnt <= cnt_after_pop + {1'b0, push};
            end
        end
    end

    a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!arstn_i)
        instr_rvalid_i |-> (out_cnt != 2'd0));
    a_gnt_needs_req: assert property (@(posedge clk_i) disable iff (!arstn_i)
        instr_gnt_i |-> instr_req_o);
    a_fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!arstn_i)
        push |-> (cnt_after_pop != 2'd2));

endmodule
